sram_pixel_fetcher: RTL

SRAM_PIXEL_FETCHER -- requirements
Module: sram_pixel_fetcher

---
 rtl/sram_pixel_fetcher_pkg.sv | 31 +++
 rtl/sram_pixel_fetcher_cache.sv | 42 ++++
 rtl/sram_pixel_fetcher.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sram_pixel_fetcher_pkg.sv
// Shared SRAM/map widths, fetch FSM states and the response payload for the pixel fetcher.
package sram_param;

  localparam int unsigned SRAM_ADDR_WIDTH    = 20;
  localparam int unsigned SRAM_DATA_WIDTH    = 16;
  localparam int unsigned COLOR_WIDTH        = 4;
  localparam int unsigned MAP_H_WIDTH        = 8;
  localparam int unsigned MAP_V_WIDTH        = 8;
  localparam int unsigned WAIT_CNT_WIDTH     = 4;
  localparam int unsigned PIX_PER_WORD_LOG2  = $clog2(SRAM_DATA_WIDTH / COLOR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [MAP_H_WIDTH+MAP_V_WIDTH-1:0] index;
    logic [SRAM_DATA_WIDTH-1:0]         data;
  } pixel_rsp_t;

  // Word address holding a given linear pixel index, wrapping at the SRAM size.
  function automatic logic [SRAM_ADDR_WIDTH-1:0] word_addr(
    input logic [SRAM_ADDR_WIDTH-1:0]           base,
    input logic [MAP_H_WIDTH+MAP_V_WIDTH-1:0]   index
  );
    return base + SRAM_ADDR_WIDTH'(index >> PIX_PER_WORD_LOG2);
  endfunction

endpackage

// File: rtl/sram_pixel_fetcher_cache.sv
// Single-entry word cache: last fetched SRAM word, its address and a valid bit.
module sram_word_cache
  import sram_param::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_invalidate,
  input  logic                       i_fill,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_fill_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_fill_data,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_lookup_addr,
  output logic                       o_hit_c,
  output logic [SRAM_DATA_WIDTH-1:0] o_word
);

  logic                       r_valid;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [SRAM_DATA_WIDTH-1:0] r_word;

  // Invalidate wins over a simultaneous fill: the word just read may already be stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_word  <= '0;
    end else begin
      if (i_invalidate) begin
        r_valid <= 1'b0;
      end else if (i_fill) begin
        r_valid <= 1'b1;
      end
      if (i_fill) begin
        r_addr <= i_fill_addr;
        r_word <= i_fill_data;
      end
    end
  end

  assign o_hit_c = r_valid && (r_addr == i_lookup_addr) && !i_invalidate;
  assign o_word  = r_word;

endmodule

// File: rtl/sram_pixel_fetcher.sv
// Fetches the 16-bit SRAM word holding a requested object pixel (read-only SRAM port).
// Optional single-word cache enabled by defining SRAM_FETCH_CACHE_EN.
module sram_pixel_fetcher
  import sram_param::*;
#(
  parameter int unsigned                 READ_WAIT = 2,
  parameter logic [SRAM_ADDR_WIDTH-1:0]  BASE_ADDR = '0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic [MAP_H_WIDTH+MAP_V_WIDTH-1:0]   i_pixel_index,
  output logic                                 o_rsp_valid,
  input  logic                                 i_rsp_ready,
  output logic [MAP_H_WIDTH+MAP_V_WIDTH-1:0]   o_pixel_index,
  output logic [SRAM_DATA_WIDTH-1:0]           o_sram_data,
  input  logic                                 i_invalidate,
  output logic [SRAM_ADDR_WIDTH-1:0]           o_SRAM_ADDR,
  output logic                                 o_SRAM_WE_N,
  output logic                                 o_SRAM_CE_N,
  output logic                                 o_SRAM_OE_N,
  output logic                                 o_SRAM_LB_N,
  output logic                                 o_SRAM_UB_N,
  inout  wire  [SRAM_DATA_WIDTH-1:0]           io_SRAM_DQ
);

  fetch_state_e                r_state;
  fetch_state_e                w_next_state;
  logic                        r_req_ready;
  logic                        r_rsp_valid;
  logic                        r_strobe_n;
  logic [SRAM_ADDR_WIDTH-1:0]  r_sram_addr;
  logic [WAIT_CNT_WIDTH-1:0]   r_wait_cnt;
  pixel_rsp_t                  r_rsp;

  logic                        w_accept;
  logic                        w_read_done;
  logic                        w_hit;
  logic [SRAM_ADDR_WIDTH-1:0]  w_req_addr;
  logic [SRAM_DATA_WIDTH-1:0]  w_cache_word;
  logic                        w_req_ready_d;
  logic                        w_rsp_valid_d;
  logic                        w_strobe_n_d;

  assign w_accept    = i_req_valid && r_req_ready;
  assign w_req_addr  = word_addr(BASE_ADDR, i_pixel_index);
  assign w_read_done = (r_state == ST_READ) && (r_wait_cnt == '0);

`ifdef SRAM_FETCH_CACHE_EN
  sram_word_cache u_cache (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_invalidate  (i_invalidate),
    .i_fill        (w_read_done),
    .i_fill_addr   (r_sram_addr),
    .i_fill_data   (io_SRAM_DQ),
    .i_lookup_addr (w_req_addr),
    .o_hit_c       (w_hit),
    .o_word        (w_cache_word)
  );
`else
  logic w_unused_invalidate;
  assign w_unused_invalidate = i_invalidate;
  assign w_hit               = 1'b0;
  assign w_cache_word        = '0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = w_hit ? ST_RESP : ST_READ;
      ST_READ: if (w_read_done) w_next_state = ST_RESP;
      ST_RESP: if (i_rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight off a flop
  always_comb begin
    w_req_ready_d = 1'b0;
    w_rsp_valid_d = 1'b0;
    w_strobe_n_d  = 1'b1;
    case (w_next_state)
      ST_IDLE: w_req_ready_d = 1'b1;
      ST_READ: w_strobe_n_d  = 1'b0;
      ST_RESP: w_rsp_valid_d = 1'b1;
      default: w_req_ready_d = 1'b0;
    endcase
  end

  // Registered outputs, wait counter and captured request/response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_strobe_n  <= 1'b1;
      r_sram_addr <= '0;
      r_wait_cnt  <= '0;
      r_rsp       <= '0;
    end else begin
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_strobe_n  <= w_strobe_n_d;
      if (w_accept) begin
        r_rsp.index <= i_pixel_index;
        r_wait_cnt  <= WAIT_CNT_WIDTH'(READ_WAIT - 1);
        if (w_hit) begin
          r_rsp.data <= w_cache_word;
        end else begin
          r_sram_addr <= w_req_addr;
        end
      end else if (r_state == ST_READ) begin
        if (w_read_done) begin
          r_rsp.data <= io_SRAM_DQ;
        end else begin
          r_wait_cnt <= r_wait_cnt - WAIT_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_pixel_index = r_rsp.index;
  assign o_sram_data   = r_rsp.data;
  assign o_SRAM_ADDR   = r_sram_addr;
  assign o_SRAM_WE_N   = 1'b1;
  assign o_SRAM_CE_N   = r_strobe_n;
  assign o_SRAM_OE_N   = r_strobe_n;
  assign o_SRAM_LB_N   = r_strobe_n;
  assign o_SRAM_UB_N   = r_strobe_n;
  assign io_SRAM_DQ    = {SRAM_DATA_WIDTH{1'bz}};

endmodule
